// File: rtl/complex_feeder_pkg.sv
// Shared definitions for the complex row feeder: FSM encoding, default widths
// and the minimum spacing between package presentations.
package complex_feeder_pkg;

  localparam int DEF_NO_OF_UNITS   = 8;
  localparam int DEF_ELEMENT_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH    = 13;
  localparam int DEF_PKG_GAP       = 4;
  localparam int PKG_GAP_MIN       = 3;

  localparam int MULT_W = 32;
  localparam int ROW_W  = 16;
  localparam int PROD_W = MULT_W + ROW_W;

  typedef enum logic [2:0] {
    IDLE,
    ROW_INIT,
    FETCH,
    PRESENT,
    GAP,
    WAIT_RES,
    EMIT,
    DONE
  } state_t;

  // FETCH and PRESENT take two cycles of every package slot, so at least one
  // GAP cycle is needed; smaller requests are raised to the minimum.
  function automatic int eff_gap(input int requested);
    return (requested < PKG_GAP_MIN) ? PKG_GAP_MIN : requested;
  endfunction

endpackage

// File: rtl/complex_feeder_addr_gen.sv
// Package-memory address generation: matrix row stride plus package index,
// vector offset by package index, both wrapping at the address width.
module complex_feeder_addr_gen
  import complex_feeder_pkg::*;
#(
  parameter int addr_width = DEF_ADDR_WIDTH
) (
  input  logic [addr_width-1:0] mat_base,
  input  logic [addr_width-1:0] vec_base,
  input  logic [ROW_W-1:0]      row,
  input  logic [MULT_W-1:0]     no_of_multiples,
  input  logic [MULT_W-1:0]     k,
  output logic [addr_width-1:0] mat_addr,
  output logic [addr_width-1:0] vec_addr
);

  logic [PROD_W-1:0] row_offset;

  // Full-width product first; truncation happens only on the final sum.
  assign row_offset = PROD_W'(row) * PROD_W'(no_of_multiples);

  assign mat_addr = addr_width'(row_offset + PROD_W'(k) + PROD_W'(mat_base));
  assign vec_addr = addr_width'(PROD_W'(k) + PROD_W'(vec_base));

endmodule

// File: rtl/complex_row_feeder.sv
// Streams matrix rows and the shared vector, one package at a time, into a
// dot-product unit and reports one result per matrix row.
module complex_row_feeder
  import complex_feeder_pkg::*;
#(
  parameter int no_of_units   = DEF_NO_OF_UNITS,
  parameter int element_width = DEF_ELEMENT_WIDTH,
  parameter int addr_width    = DEF_ADDR_WIDTH,
  parameter int pkg_gap       = DEF_PKG_GAP
) (
  input  logic                                 clk,
  input  logic                                 main_reset,
  input  logic                                 start,
  output logic                                 busy,
  input  logic [31:0]                          no_of_multiples_in,
  input  logic [15:0]                          no_of_rows,
  input  logic [addr_width-1:0]                mat_base,
  input  logic [addr_width-1:0]                vec_base,
  output logic [addr_width-1:0]                mat_addr,
  output logic [addr_width-1:0]                vec_addr,
  input  logic [element_width*no_of_units-1:0] mat_data,
  input  logic [element_width*no_of_units-1:0] vec_data,
  output logic [element_width*no_of_units-1:0] first_row_input,
  output logic [element_width*no_of_units-1:0] second_row_input,
  output logic                                 outsider_read_now,
  output logic [31:0]                          no_of_multiples,
  output logic                                 dp_reset,
  output logic                                 dp_main_reset,
  input  logic                                 dp_finish,
  input  logic [element_width-1:0]             dp_result,
  output logic                                 result_valid,
  output logic [element_width-1:0]             result_data,
  output logic [15:0]                          result_row,
  output logic                                 done
);

  localparam int          GAP_EFF    = eff_gap(pkg_gap);
  localparam logic [31:0] GAP_RELOAD = 32'(GAP_EFF - 3);

  state_t                  state, state_nxt;
  logic [31:0]             n_r;
  logic [31:0]             k;
  logic [31:0]             gap_cnt;
  logic [15:0]             rows_r;
  logic [15:0]             row;
  logic [addr_width-1:0]   mat_base_r;
  logic [addr_width-1:0]   vec_base_r;
  logic                    empty_job;
  logic                    last_pkg;
  logic                    more_rows;
  logic                    capture;

  assign empty_job = (no_of_multiples_in == 32'd0) || (no_of_rows == 16'd0);
  assign last_pkg  = (k == n_r - 32'd1);
  assign more_rows = (17'(row) + 17'd1) < 17'(rows_r);
  assign capture   = (state == WAIT_RES) && dp_finish;

  assign no_of_multiples = n_r;

  complex_feeder_addr_gen #(
    .addr_width(addr_width)
  ) u_addr_gen (
    .mat_base        (mat_base_r),
    .vec_base        (vec_base_r),
    .row             (row),
    .no_of_multiples (n_r),
    .k               (k),
    .mat_addr        (mat_addr),
    .vec_addr        (vec_addr)
  );

  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    dp_reset      = (state == ROW_INIT) && !main_reset;
    dp_main_reset = main_reset || (state == ROW_INIT);
    case (state)
      IDLE:     if (start) state_nxt = empty_job ? DONE : ROW_INIT;
      ROW_INIT: state_nxt = FETCH;
      FETCH:    state_nxt = PRESENT;
      PRESENT:  state_nxt = GAP;
      GAP:      if (gap_cnt == 32'd0) state_nxt = last_pkg ? WAIT_RES : FETCH;
      WAIT_RES: if (dp_finish) state_nxt = EMIT;
      EMIT:     state_nxt = more_rows ? ROW_INIT : DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (main_reset) begin
      state             <= IDLE;
      n_r               <= '0;
      rows_r            <= '0;
      mat_base_r        <= '0;
      vec_base_r        <= '0;
      row               <= '0;
      k                 <= '0;
      gap_cnt           <= '0;
      first_row_input   <= '0;
      second_row_input  <= '0;
      outsider_read_now <= 1'b0;
      result_valid      <= 1'b0;
      result_data       <= '0;
      result_row        <= '0;
      done              <= 1'b0;
    end else begin
      state             <= state_nxt;
      outsider_read_now <= (state == PRESENT);
      result_valid      <= capture;
      done              <= (state == DONE);
      case (state)
        IDLE: begin
          if (start && !empty_job) begin
            n_r        <= no_of_multiples_in;
            rows_r     <= no_of_rows;
            mat_base_r <= mat_base;
            vec_base_r <= vec_base;
            row        <= '0;
          end
        end
        ROW_INIT: k <= '0;
        // Memory data arrives one cycle after FETCH; register it together
        // with the pulse so the dot-product unit sees both in the same cycle.
        PRESENT: begin
          first_row_input  <= mat_data;
          second_row_input <= vec_data;
          gap_cnt          <= GAP_RELOAD;
        end
        GAP: begin
          if (gap_cnt != 32'd0) gap_cnt <= gap_cnt - 32'd1;
          else if (!last_pkg)   k       <= k + 32'd1;
        end
        WAIT_RES: begin
          if (dp_finish) begin
            result_data <= dp_result;
            result_row  <= row;
          end
        end
        EMIT: row <= row + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_row_feeder.sv
// Scoreboard bench for complex_row_feeder with a synchronous memory model and
// a dot-product stub that sums the element-0 real parts it is fed.
module tb_complex_row_feeder;

  localparam int UNITS = 8;
  localparam int EW    = 64;
  localparam int AW    = 13;
  localparam int BUS   = UNITS * EW;
  localparam int GAPC  = 4;

  logic           clk = 1'b0;
  logic           main_reset;
  logic           start;
  logic           busy;
  logic [31:0]    no_of_multiples_in;
  logic [15:0]    no_of_rows;
  logic [AW-1:0]  mat_base, vec_base, mat_addr, vec_addr;
  logic [BUS-1:0] mat_data, vec_data, first_row_input, second_row_input;
  logic           outsider_read_now;
  logic [31:0]    no_of_multiples;
  logic           dp_reset, dp_main_reset, dp_finish;
  logic [EW-1:0]  dp_result, result_data;
  logic           result_valid, done;
  logic [15:0]    result_row;

  always #5 clk = ~clk;

  complex_row_feeder #(
    .no_of_units(UNITS), .element_width(EW), .addr_width(AW), .pkg_gap(GAPC)
  ) dut (
    .clk(clk), .main_reset(main_reset), .start(start), .busy(busy),
    .no_of_multiples_in(no_of_multiples_in), .no_of_rows(no_of_rows),
    .mat_base(mat_base), .vec_base(vec_base),
    .mat_addr(mat_addr), .vec_addr(vec_addr),
    .mat_data(mat_data), .vec_data(vec_data),
    .first_row_input(first_row_input), .second_row_input(second_row_input),
    .outsider_read_now(outsider_read_now), .no_of_multiples(no_of_multiples),
    .dp_reset(dp_reset), .dp_main_reset(dp_main_reset),
    .dp_finish(dp_finish), .dp_result(dp_result),
    .result_valid(result_valid), .result_data(result_data),
    .result_row(result_row), .done(done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [BUS-1:0] mat_word(input logic [AW-1:0] a);
    logic [BUS-1:0] w;
    for (int j = 0; j < UNITS; j++) w[j*EW +: EW] = {32'h1000_0000 + 32'(j), 19'd0, a};
    return w;
  endfunction

  function automatic logic [BUS-1:0] vec_word(input logic [AW-1:0] a);
    logic [BUS-1:0] w;
    for (int j = 0; j < UNITS; j++) w[j*EW +: EW] = {32'h2000_0000 + 32'(j), 19'd0, a};
    return w;
  endfunction

  // Synchronous package memories, one cycle of read latency.
  always @(posedge clk) begin
    mat_data <= mat_word(mat_addr);
    vec_data <= vec_word(vec_addr);
  end

  // Dot-product stub: result = {sum of vector addrs, sum of matrix addrs}.
  logic [31:0] st_cnt, st_msum, st_vsum;
  logic [2:0]  st_dly;
  logic        st_fin;
  logic        force_fin;
  always @(negedge clk) begin
    if (dp_main_reset) begin
      st_cnt <= '0; st_msum <= '0; st_vsum <= '0; st_dly <= '0; st_fin <= 1'b0;
    end else begin
      if (outsider_read_now) begin
        st_cnt  <= st_cnt + 32'd1;
        st_msum <= st_msum + first_row_input[31:0];
        st_vsum <= st_vsum + second_row_input[31:0];
      end
      if (st_cnt != 0 && st_cnt == no_of_multiples && !st_fin) begin
        st_dly <= st_dly + 3'd1;
        if (st_dly == 3'd3) st_fin <= 1'b1;
      end
    end
  end
  assign dp_finish = st_fin | force_fin;
  assign dp_result = {st_vsum, st_msum};

  // Scoreboard queues: {mat_addr, vec_addr} per pulse, {row, data} per result.
  logic [25:0] pkt_q[$];
  logic [79:0] res_q[$];
  int done_seen = 0, dpr_seen = 0, pulse_seen = 0, cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor
  logic [25:0]    pe;
  logic [79:0]    re;
  logic [BUS-1:0] held_f, held_s;
  int             hold_cnt = 0, last_pulse = 0;
  bit             in_row = 1'b0;
  initial forever begin
    @(negedge clk);
    if (dp_reset) dpr_seen++;
    if (done) done_seen++;
    if (main_reset) hold_cnt = 0;
    else if (hold_cnt > 0) begin
      chk("hold_first", first_row_input, held_f);
      chk("hold_second", second_row_input, held_s);
      hold_cnt--;
    end
    if (dp_main_reset) in_row = 1'b0;
    if (outsider_read_now) begin
      pulse_seen++;
      if (pkt_q.size() == 0) expired("unexpected_pulse");
      else begin
        pe = pkt_q.pop_front();
        chk("first_row_input", first_row_input, mat_word(pe[25:13]));
        chk("second_row_input", second_row_input, vec_word(pe[12:0]));
      end
      if (in_row) chk("pulse_spacing", BUS'(cyc - last_pulse), BUS'(GAPC));
      last_pulse = cyc;
      in_row     = 1'b1;
      held_f     = first_row_input;
      held_s     = second_row_input;
      hold_cnt   = 2;
    end
    if (result_valid) begin
      if (res_q.size() == 0) expired("unexpected_result");
      else begin
        re = res_q.pop_front();
        chk("result_row", BUS'(result_row), BUS'(re[79:64]));
        chk("result_data", BUS'(result_data), BUS'(re[63:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] n, input logic [15:0] r,
                           input logic [AW-1:0] mb, input logic [AW-1:0] vb);
    tick();
    no_of_multiples_in = n; no_of_rows = r; mat_base = mb; vec_base = vb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) expired(name);
  endtask

  task automatic wait_pulses(input int cnt, input string name);
    int seen = 0;
    for (int i = 0; i < 600 && seen < cnt; i++) begin
      @(negedge clk);
      if (outsider_read_now) seen++;
    end
    if (seen < cnt) expired(name);
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_busy"}, BUS'(busy), '0);
    chk({tag, "_done"}, BUS'(done), '0);
    chk({tag, "_result_valid"}, BUS'(result_valid), '0);
    chk({tag, "_read_now"}, BUS'(outsider_read_now), '0);
    chk({tag, "_dp_reset"}, BUS'(dp_reset), '0);
    chk({tag, "_dp_main_reset"}, BUS'(dp_main_reset), '0);
    chk({tag, "_first_row"}, first_row_input, '0);
    chk({tag, "_second_row"}, second_row_input, '0);
    chk({tag, "_result_data"}, BUS'(result_data), '0);
    chk({tag, "_result_row"}, BUS'(result_row), '0);
  endtask

  task automatic push_pkt(input logic [AW-1:0] m, input logic [AW-1:0] v);
    pkt_q.push_back({m, v});
  endtask

  task automatic push_res(input logic [15:0] r, input logic [63:0] d);
    res_q.push_back({r, d});
  endtask

  int s2_mat[12] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21};
  int s2_vec[12] = '{100, 101, 102, 103, 100, 101, 102, 103, 100, 101, 102, 103};
  int n0, d0, p0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    main_reset = 1'b1; start = 1'b0; force_fin = 1'b0;
    no_of_multiples_in = '0; no_of_rows = '0; mat_base = '0; vec_base = '0;
    repeat (2) @(negedge clk);
    chk("rst_dp_main_reset_high", BUS'(dp_main_reset), BUS'(1));
    chk("rst_dp_reset_low", BUS'(dp_reset), '0);
    tick();
    main_reset = 1'b0;
    @(negedge clk);
    check_idle_outs("rst");

    // Single package, single row
    push_pkt(13'd5, 13'd7);
    push_res(16'd0, 64'h0000_0007_0000_0005);
    start_job(32'd1, 16'd1, 13'd5, 13'd7);
    wait_done("s1_done");

    // Four packages, three rows
    for (int i = 0; i < 12; i++) push_pkt(AW'(s2_mat[i]), AW'(s2_vec[i]));
    push_res(16'd0, 64'h0000_0196_0000_002E);
    push_res(16'd1, 64'h0000_0196_0000_003E);
    push_res(16'd2, 64'h0000_0196_0000_004E);
    start_job(32'd4, 16'd3, 13'd10, 13'd100);
    wait_done("s2_done");

    // Empty job: done two cycles after start, no dot-product activity
    d0 = dpr_seen; p0 = pulse_seen;
    start_job(32'd0, 16'd3, 13'd0, 13'd0);
    @(negedge clk);
    chk("s3_busy", BUS'(busy), BUS'(1));
    chk("s3_done_not_yet", BUS'(done), '0);
    @(negedge clk);
    chk("s3_done_pulse", BUS'(done), BUS'(1));
    @(negedge clk);
    chk("s3_done_cleared", BUS'(done), '0);
    chk("s3_no_dp_reset", BUS'(dpr_seen), BUS'(d0));
    chk("s3_no_pulse", BUS'(pulse_seen), BUS'(p0));

    // Address wrap at the top of the package memory
    push_pkt(13'd8190, 13'd0);
    push_pkt(13'd8191, 13'd1);
    push_pkt(13'd0, 13'd2);
    push_pkt(13'd1, 13'd3);
    push_res(16'd0, 64'h0000_0006_0000_3FFE);
    start_job(32'd4, 16'd1, 13'd8190, 13'd0);
    wait_done("s4_done");

    // Restart and early dp_finish while busy are both ignored
    push_pkt(13'd40, 13'd50);
    push_pkt(13'd41, 13'd51);
    push_pkt(13'd42, 13'd50);
    push_pkt(13'd43, 13'd51);
    push_res(16'd0, 64'h0000_0065_0000_0051);
    push_res(16'd1, 64'h0000_0065_0000_0055);
    start_job(32'd2, 16'd2, 13'd40, 13'd50);
    wait_pulses(1, "s5_first_pulse");
    tick();
    start = 1'b1; no_of_multiples_in = 32'd9; no_of_rows = 16'd5;
    mat_base = 13'd1000; vec_base = 13'd2000;
    tick();
    start = 1'b0; force_fin = 1'b1;
    tick();
    tick();
    force_fin = 1'b0;
    chk("s5_no_of_multiples_stable", BUS'(no_of_multiples), BUS'(2));
    wait_done("s5_done");

    // Abort during the gap of row 1, then a clean job
    push_pkt(13'd200, 13'd300);
    push_pkt(13'd201, 13'd301);
    push_pkt(13'd202, 13'd300);
    push_res(16'd0, 64'h0000_0259_0000_0191);
    start_job(32'd2, 16'd3, 13'd200, 13'd300);
    n0 = done_seen;
    wait_pulses(3, "s6_third_pulse");
    tick();
    main_reset = 1'b1;
    @(negedge clk);
    chk("s6_dp_main_reset_in_reset", BUS'(dp_main_reset), BUS'(1));
    tick();
    main_reset = 1'b0;
    @(negedge clk);
    check_idle_outs("s6");
    repeat (20) @(negedge clk);
    chk("s6_no_done", BUS'(done_seen), BUS'(n0));
    chk("s6_pkts_left", BUS'(pkt_q.size()), '0);
    chk("s6_results_left", BUS'(res_q.size()), '0);

    push_pkt(13'd0, 13'd0);
    push_pkt(13'd1, 13'd1);
    push_pkt(13'd2, 13'd2);
    push_res(16'd0, 64'h0000_0003_0000_0003);
    start_job(32'd3, 16'd1, 13'd0, 13'd0);
    wait_done("s7_done");

    repeat (3) @(negedge clk);
    chk("final_done_count", BUS'(done_seen), BUS'(6));
    chk("final_pkts_left", BUS'(pkt_q.size()), '0);
    chk("final_results_left", BUS'(res_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/complex_row_feeder.md
COMPLEX_ROW_FEEDER -- requirements
Module: complex_row_feeder

Interface
REQ-001 SHALL have parameter no_of_units, default 8, meaning complex elements per package.
REQ-002 SHALL have parameter element_width, default 64, meaning bits per complex element (32 real, 32 imaginary).
REQ-003 SHALL have parameter addr_width, default 13, meaning package-memory address width.
REQ-004 SHALL have parameter pkg_gap, default 4, minimum 3, meaning cycles between successive outsider_read_now pulses.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on posedge; reset is synchronous and active-high.
REQ-006 SHALL have port main_reset  in  1  synchronous active-high block reset.
REQ-007 SHALL have ports start  in  1 and busy  out  1, meaning job request and job in progress.
REQ-008 SHALL have ports no_of_multiples_in  in  32, no_of_rows  in  16, mat_base and vec_base  in  addr_width, all sampled on accepted start.
REQ-009 SHALL have ports mat_addr and vec_addr  out  addr_width, mat_data and vec_data  in  element_width*no_of_units, reading synchronous memories with 1-cycle latency.
REQ-010 SHALL have ports first_row_input and second_row_input  out  element_width*no_of_units, outsider_read_now  out  1, no_of_multiples  out  32, dp_reset  out  1, dp_main_reset  out  1, all driving the dot-product unit.
REQ-011 SHALL have ports dp_finish  in  1 and dp_result  in  element_width, from the dot-product unit.
REQ-012 SHALL have ports result_valid  out  1, result_data  out  element_width, result_row  out  16, and done  out  1.

Function
REQ-013 SHALL use states IDLE, ROW_INIT, FETCH, PRESENT, GAP, WAIT_RES, EMIT, DONE.
REQ-014 IDLE: start accepted only in IDLE; if no_of_multiples_in==0 or no_of_rows==0, go to DONE with no dot-product activity, else latch the inputs, set row=0, and go to ROW_INIT.
REQ-015 ROW_INIT: one cycle with dp_main_reset=1 and dp_reset=1, and no_of_multiples driven with the latched value; this value SHALL stay stable until DONE.
REQ-016 FETCH: drive mat_addr=mat_base+row*no_of_multiples+k and vec_addr=vec_base+k, where k is the package index 0..N-1, with addresses wrapping modulo 2^addr_width.
REQ-017 PRESENT: one cycle after FETCH, register mat_data into first_row_input and vec_data into second_row_input, and pulse outsider_read_now for exactly that cycle.
REQ-018 first_row_input and second_row_input SHALL hold stable from the pulse cycle through at least pulse+2, because upper halves are consumed at pulse+1 and lower halves at pulse+2.
REQ-019 Successive outsider_read_now pulses SHALL be exactly pkg_gap cycles apart within a row; GAP counts the remaining cycles, then returns to FETCH, or goes to WAIT_RES after package N-1.
REQ-020 WAIT_RES: on the first cycle dp_finish==1, capture dp_result and go to EMIT; outsider_read_now SHALL stay low.
REQ-021 EMIT: assert result_valid for one cycle with result_data=captured value and result_row=row; then row+1, returning to ROW_INIT if row+1<no_of_rows, else going to DONE.
REQ-022 DONE: pulse done for one cycle, then go to IDLE; busy=1 in every state except IDLE.
REQ-023 start asserted while busy SHALL be ignored, with no latching and no effect.
REQ-024 dp_finish high outside WAIT_RES SHALL be ignored; dp_finish is cleared only by dp_main_reset.
REQ-025 The package counter k SHALL be 32 bits wide; row*no_of_multiples SHALL be computed at full width, then truncated to addr_width.

Reset
REQ-026 When main_reset=1 at a posedge: state=IDLE; busy, done, result_valid, outsider_read_now and dp_reset=0; dp_main_reset=1 in that cycle; row, k, result_data, result_row, first_row_input and second_row_input=0.
REQ-027 main_reset SHALL abort any job mid-operation with no result_valid and no done; main_reset SHALL take priority over start in the same cycle.

Structure
REQ-028 State encoding, default widths, and the pkg_gap minimum SHALL be placed in a shared package, complex_feeder_pkg.
REQ-029 Address generation (REQ-016, REQ-025) SHALL be one sub-module, complex_feeder_addr_gen; all other logic SHALL be flat in this module.

Verification
REQ-030 Scenario: N=1, rows=1, mat[0]=A, vec[0]=B -> exactly one outsider_read_now; after dp_finish, result_valid with result_row=0, then done.
REQ-031 Scenario: N=4, rows=3, mat_base=10, vec_base=100 -> mat_addr sequence 10..21, vec_addr 100..103 repeated 3 times; pulse spacing=4; result_row 0, 1, 2 in order.
REQ-032 Scenario: N=0 -> done exactly 2 cycles after start; no dp_reset and no outsider_read_now.
REQ-033 Scenario: mat_base=8190, N=4 -> addresses 8190, 8191, 0, 1.
REQ-034 Scenario: start re-asserted mid-job, and dp_finish forced high during PRESENT -> both ignored; the job completes unchanged.
REQ-035 Scenario: main_reset during GAP of row 1 -> all outputs at reset values next cycle, no done; a new start then runs normally.
